// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-multiplexed scanner for an 8-digit common-anode 7-segment display.
// Double-buffered hex/DP/enable registers that commit only at frame boundaries, so the display never tears.
// Optional feature: define SEG7_LZ_BLANK_EN to blank leading zero digits.
//   Digit 0 is never blanked, and a lit DP keeps its digit visible.
module seg7_scan_mux #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        CLK100MHZ,
  input  logic        RST,
  input  logic [31:0] DATA,
  input  logic [7:0]  DP_MASK,
  input  logic [7:0]  EN_MASK,
  input  logic        LOAD,
  output logic        BUSY,
  output logic        FRAME,
  output logic [7:0]  SEG,
  output logic [7:0]  AN
);

  localparam int unsigned CNT_W   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned DIGITS  = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  // One display image: hex word plus per-digit DP and enable masks
  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  dp;
    logic [7:0]  en;
  } disp_t;

  localparam disp_t DISP_RST = '{data: 32'h0000_0000, dp: 8'h00, en: 8'hFF};

  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             tick_c;
  logic             wrap_c;
  disp_t            disp_q;
  disp_t            pend_q;
  disp_t            in_c;
  logic [3:0]       nib_c;
  logic [6:0]       glyph_c;
  logic [7:0]       lz_c;
  logic             digit_on_c;

  // Hex nibble to active-low segment pattern {CG..CA}
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    s = 7'h7F;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign in_c   = '{data: DATA, dp: DP_MASK, en: EN_MASK};
  assign tick_c = (cnt == CNT_MAX);
  assign wrap_c = tick_c && (idx == IDX_LAST);

  // Slot prescaler: counts 0..SCAN_DIV-1, wraps on tick
  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      cnt <= '0;
    end else if (tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Digit scan index, advances once per slot and wraps 7->0 naturally
  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      idx <= '0;
    end else if (tick_c) begin
      idx <= idx + IDX_W'(1);
    end
  end

  // Frame pulse in the cycle after the 7->0 wrap edge
  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      FRAME <= 1'b0;
    end else begin
      FRAME <= wrap_c;
    end
  end

  // Double buffer: loads park in pending, commit on the wrap; a load on the wrap edge goes straight through
  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      disp_q <= DISP_RST;
      pend_q <= '0;
      BUSY   <= 1'b0;
    end else if (wrap_c) begin
      if (LOAD) begin
        disp_q <= in_c;
        BUSY   <= 1'b0;
      end else if (BUSY) begin
        disp_q <= pend_q;
        BUSY   <= 1'b0;
      end
    end else if (LOAD) begin
      pend_q <= in_c;
      BUSY   <= 1'b1;
    end
  end

`ifdef SEG7_LZ_BLANK_EN
  // Leading-zero mask: digit i>0 blanks when it and all higher nibbles are zero and its DP is off
  always_comb begin
    logic zero_above;
    lz_c       = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (disp_q.data[4*i +: 4] == 4'h0);
      lz_c[i]    = zero_above && !disp_q.dp[i];
    end
  end
`else
  assign lz_c = '0;
`endif

  assign nib_c      = disp_q.data[{idx, 2'b00} +: 4];
  assign glyph_c    = decode(nib_c);
  assign digit_on_c = disp_q.en[idx] && !lz_c[idx];

  // Registered pin drivers for the current slot
  always_ff @(posedge CLK100MHZ) begin
    if (RST) begin
      SEG <= 8'hFF;
      AN  <= 8'hFF;
    end else begin
      SEG <= {~disp_q.dp[idx], glyph_c};
      AN  <= digit_on_c ? ~(8'(1) << idx) : 8'hFF;
    end
  end

endmodule
